pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Pipelined successor to the single-cycle control unit for the 5-stage RV32I core.
- Decodes in D and carries the control bundle through the D/E, E/M and M/W registers.
- Resolves all six branch conditions plus jal/jalr in E.
- Supports stall and flush from the hazard unit, and flags illegal opcodes.

Parameters:
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_CTRL_WIDTH, 4, ALUControl width
- IMM_SRC_WIDTH, 3, ImmSrc width
- ALU_OP_WIDTH, 3, internal ALUOp width
- RESULT_SRC_WIDTH, 2, ResultSrc width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- op_d  in  OP_WIDTH  opcode of D-stage instruction
- funct3_d  in  FUNCT3_WIDTH  funct3 in D
- funct7_5_d  in  1  instr[30] in D
- stall_e  in  1  hold D/E register
- flush_e  in  1  load bubble into D/E register
- zero_e, n_e, c_e, v_e  in  1 each  ALU flags of E-stage instruction
- ImmSrcD  out  IMM_SRC_WIDTH  immediate select, combinational in D
- IllegalD  out  1  D opcode not RV32I base
- ALUControlE  out  ALU_CTRL_WIDTH  registered
- ALUSrcE  out  1  registered
- ResultSrcE  out  RESULT_SRC_WIDTH  registered, for load-use detection
- PCSrcE  out  1  redirect fetch, combinational from E register and flags
- PCTargetSrcE  out  1  0 = PC+imm, 1 = ALU result (jalr)
- RegWriteM, MemWriteM  out  1 each  registered
- ResultSrcM  out  RESULT_SRC_WIDTH  registered
- RegWriteW  out  1  registered
- ResultSrcW  out  RESULT_SRC_WIDTH  registered

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: every stage register loads the bubble. Bubble is all-zero: RegWrite=0, MemWrite=0, Branch=0, Jump=0, JumpR=0, ResultSrc=00, ALUControl=0000, ALUSrc=0. All registered outputs read 0 on the cycle after rst is sampled high. PCSrcE=0 while E holds a bubble.
- rst mid-operation: in-flight instructions are discarded with no write enable surviving; rst overrides stall_e and flush_e.
- D decode (combinational):
  - ResultSrc encoding: 00 ALU, 01 load data, 10 PC+4 (jal/jalr), 11 ImmExt (lui).
  - auipc: ALUSrc=1, ALU A-input select is outside this block, ResultSrc=00.
  - Unknown opcode: IllegalD=1, and the decoded bundle is forced to bubble.
- D/E register priority per cycle: rst > flush_e > stall_e > load. flush_e and stall_e together give a bubble.
- E/M and M/W registers advance every cycle; they have no stall.
- Latency: control for an instruction decoded in cycle t appears at E outputs in t+1, M in t+2, W in t+3, absent stall/flush.
- Branch resolution in E, with flags from A−B where c_e = carry-out of A+~B+1:
  - beq: zero_e
  - bne: ~zero_e
  - blt: n_e^v_e
  - bge: ~(n_e^v_e)
  - bltu: ~c_e
  - bgeu: c_e
  - funct3 010/011 on a branch: no redirect.
- PCSrcE = (BranchE & cond) | JumpE | JumpRE. PCTargetSrcE = JumpRE.
- Branch funct3 is carried in the D/E register; the condition is never taken from D.
- Flush interaction: the hazard unit asserts flush_e in the cycle PCSrcE=1. The E instruction itself still proceeds to M, so jal/jalr write rd.
- Stall holds all E outputs stable, including PCSrcE if flags are stable.

Decomposition:
- Package control_pkg:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - branch funct3 constants
  - ResultSrc encodings
  - packed struct ctrl_bundle_t for the D/E payload
  - CTRL_BUBBLE constant
- Reuse main_decoder and alu_decoder unchanged for D decode.
- One new combinational sub-module, branch_unit: inputs funct3, flags, Branch, Jump, JumpR; outputs PCSrc and PCTargetSrc.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles with op_d=0110011 → every E/M/W output 0, PCSrcE=0. First add reaches RegWriteW=1 exactly 3 cycles after rst drops.
- Pipeline latency: add, lw, sw, lui issued back-to-back:
  - ResultSrcW sequence is 00, 01, —, 11.
  - MemWriteM=1 only in the sw M cycle.
  - RegWriteW pattern is 1,1,0,1.
- Branch matrix: beq/bne/blt/bge/bltu/bgeu each with A=−1, B=1 → PCSrcE = 0,1,1,0,0,1 respectively. The unsigned cases use c_e from 0xFFFFFFFF−1.
- jalr: op_d=1100111 → PCSrcE=1, PCTargetSrcE=1, ResultSrcW=10, RegWriteW=1 three cycles later.
- Stall/flush: stall_e=1 for 2 cycles holds ALUControlE constant. flush_e=1 with stall_e=1 gives a bubble (RegWriteM=0 next cycle). A taken beq plus flush_e leaves the younger instruction with no M/W effects.
- Illegal opcode: op_d=0000000 → IllegalD=1 and no write enable reaches M or W. Asserting rst while a sw is in E leaves MemWriteM=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the pipelined RV32I control path.
// Opcodes, branch funct3 codes, ResultSrc/ImmSrc/ALUOp/ALUControl encodings
// and the D/E control payload, together with its all-zero bubble value.
package control_pkg;

  localparam int OP_W         = 7;
  localparam int F3_W         = 3;
  localparam int ALU_CTRL_W   = 4;
  localparam int IMM_SRC_W    = 3;
  localparam int ALU_OP_W     = 3;
  localparam int RESULT_SRC_W = 2;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [RESULT_SRC_W-1:0] RS_ALU = 2'b00;
  localparam logic [RESULT_SRC_W-1:0] RS_MEM = 2'b01;
  localparam logic [RESULT_SRC_W-1:0] RS_PC4 = 2'b10;
  localparam logic [RESULT_SRC_W-1:0] RS_IMM = 2'b11;

  localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b100;

  localparam logic [ALU_OP_W-1:0] ALUOP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALUOP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALUOP_R   = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALUOP_I   = 3'b011;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

  // funct3 rides along so the branch condition is evaluated from E, never D.
  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic                    branch;
    logic                    jump;
    logic                    jump_r;
    logic [RESULT_SRC_W-1:0] result_src;
    logic [ALU_CTRL_W-1:0]   alu_control;
    logic                    alu_src;
    logic [F3_W-1:0]         funct3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder (combinational).
// in : alu_op, funct3, funct7_5, op_5 (distinguishes R-type sub from addi)
// out: alu_control
module alu_decoder
  import control_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic [F3_W-1:0]       funct3,
  input  logic                  funct7_5,
  input  logic                  op_5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000:  alu_control = (funct7_5 && op_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// E-stage redirect logic (combinational).
// in : funct3, zero/n/c/v flags of A-B (c = carry of A+~B+1), branch, jump, jump_r
// out: pc_src (redirect fetch), pc_target_src (0 = PC+imm, 1 = ALU result)
module branch_unit
  import control_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            zero,
  input  logic            n,
  input  logic            c,
  input  logic            v,
  input  logic            branch,
  input  logic            jump,
  input  logic            jump_r,
  output logic            pc_src,
  output logic            pc_target_src
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = ~(n ^ v);
      F3_BLTU: cond = ~c;
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end

  assign pc_src        = (branch & cond) | jump | jump_r;
  assign pc_target_src = jump_r;

endmodule

// File: rtl/main_decoder.sv
// Main opcode decoder (combinational).
// in : op
// out: reg_write, mem_write, branch, jump, jump_r, alu_src, result_src,
//      imm_src, alu_op, illegal (unknown opcode; all other outputs zero)
module main_decoder
  import control_pkg::*;
(
  input  logic [OP_W-1:0]         op,
  output logic                    reg_write,
  output logic                    mem_write,
  output logic                    branch,
  output logic                    jump,
  output logic                    jump_r,
  output logic                    alu_src,
  output logic [RESULT_SRC_W-1:0] result_src,
  output logic [IMM_SRC_W-1:0]    imm_src,
  output logic [ALU_OP_W-1:0]     alu_op,
  output logic                    illegal
);

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jump_r     = 1'b0;
    alu_src    = 1'b0;
    result_src = RS_ALU;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (op)
      OP_R:      begin reg_write = 1'b1; alu_op = ALUOP_R; end
      OP_I:      begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_I; end
      OP_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RS_MEM; end
      OP_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
      OP_BRANCH: begin branch = 1'b1; imm_src = IMM_B; alu_op = ALUOP_SUB; end
      OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; imm_src = IMM_J; result_src = RS_PC4; end
      // jalr target is computed by the ALU as rs1 + imm.
      OP_JALR:   begin reg_write = 1'b1; jump_r = 1'b1; alu_src = 1'b1; result_src = RS_PC4; end
      OP_LUI:    begin reg_write = 1'b1; imm_src = IMM_U; result_src = RS_IMM; end
      // auipc: the ALU A-input PC select lives in the datapath.
      OP_AUIPC:  begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_U; end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit for the 5-stage RV32I core.
// Decodes in D, carries the control bundle through D/E, E/M and M/W, and
// resolves branches/jumps in E.
// in : clk, rst (sync, active-high), op_d, funct3_d, funct7_5_d,
//      stall_e, flush_e, zero_e, n_e, c_e, v_e
// out: ImmSrcD, IllegalD (D, combinational); ALUControlE, ALUSrcE,
//      ResultSrcE (registered); PCSrcE, PCTargetSrcE (combinational from E);
//      RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW (registered)
module pipelined_control_unit
  import control_pkg::*;
#(
  parameter int OP_WIDTH         = 7,
  parameter int FUNCT3_WIDTH     = 3,
  parameter int ALU_CTRL_WIDTH   = 4,
  parameter int IMM_SRC_WIDTH    = 3,
  parameter int ALU_OP_WIDTH     = 3,
  parameter int RESULT_SRC_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [OP_WIDTH-1:0]         op_d,
  input  logic [FUNCT3_WIDTH-1:0]     funct3_d,
  input  logic                        funct7_5_d,
  input  logic                        stall_e,
  input  logic                        flush_e,
  input  logic                        zero_e,
  input  logic                        n_e,
  input  logic                        c_e,
  input  logic                        v_e,
  output logic [IMM_SRC_WIDTH-1:0]    ImmSrcD,
  output logic                        IllegalD,
  output logic [ALU_CTRL_WIDTH-1:0]   ALUControlE,
  output logic                        ALUSrcE,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
  output logic                        PCSrcE,
  output logic                        PCTargetSrcE,
  output logic                        RegWriteM,
  output logic                        MemWriteM,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
  output logic                        RegWriteW,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW
);

  logic                  reg_write_d, mem_write_d, branch_d, jump_d, jump_r_d, alu_src_d;
  logic [RESULT_SRC_W-1:0] result_src_d;
  logic [ALU_OP_W-1:0]   alu_op_d;
  logic [ALU_CTRL_W-1:0] alu_control_d;
  ctrl_bundle_t          ctrl_d;
  ctrl_bundle_t          ctrl_p1;

  main_decoder u_main_decoder (
    .op         (op_d),
    .reg_write  (reg_write_d),
    .mem_write  (mem_write_d),
    .branch     (branch_d),
    .jump       (jump_d),
    .jump_r     (jump_r_d),
    .alu_src    (alu_src_d),
    .result_src (result_src_d),
    .imm_src    (ImmSrcD),
    .alu_op     (alu_op_d),
    .illegal    (IllegalD)
  );

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_d),
    .funct3      (funct3_d),
    .funct7_5    (funct7_5_d),
    .op_5        (op_d[5]),
    .alu_control (alu_control_d)
  );

  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    ctrl_d.reg_write   = reg_write_d;
    ctrl_d.mem_write   = mem_write_d;
    ctrl_d.branch      = branch_d;
    ctrl_d.jump        = jump_d;
    ctrl_d.jump_r      = jump_r_d;
    ctrl_d.result_src  = result_src_d;
    ctrl_d.alu_control = alu_control_d;
    ctrl_d.alu_src     = alu_src_d;
    ctrl_d.funct3      = funct3_d;
    if (IllegalD) ctrl_d = CTRL_BUBBLE;
  end

  // D/E boundary: rst > flush_e > stall_e > load
  always_ff @(posedge clk) begin
    if (rst || flush_e) ctrl_p1 <= CTRL_BUBBLE;
    else if (!stall_e)  ctrl_p1 <= ctrl_d;
  end

  assign ALUControlE = ctrl_p1.alu_control;
  assign ALUSrcE     = ctrl_p1.alu_src;
  assign ResultSrcE  = ctrl_p1.result_src;

  branch_unit u_branch_unit (
    .funct3        (ctrl_p1.funct3),
    .zero          (zero_e),
    .n             (n_e),
    .c             (c_e),
    .v             (v_e),
    .branch        (ctrl_p1.branch),
    .jump          (ctrl_p1.jump),
    .jump_r        (ctrl_p1.jump_r),
    .pc_src        (PCSrcE),
    .pc_target_src (PCTargetSrcE)
  );

  // E/M boundary: advances every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= RS_ALU;
    end else begin
      RegWriteM  <= ctrl_p1.reg_write;
      MemWriteM  <= ctrl_p1.mem_write;
      ResultSrcM <= ctrl_p1.result_src;
    end
  end

  // M/W boundary: advances every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RS_ALU;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
    end
  end

endmodule
